uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter with an input FIFO and runtime-selectable frame format. It accepts words over a valid/ready handshake, buffers up to `DEPTH` of them, and serialises each as start bit, `DATA_W` data bits (LSB first), optional parity bit, and 1 or 2 stop bits on `tx_o`. It sits between the bus-side register block and the pad, and replaces the fixed 8N1 transmitter in new designs.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `DIV_W`, default 14: width of the baud divider.
- `DEPTH`, default 4: FIFO depth in words; a power of 2, ≥ 2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `divider_i`  in  DIV_W  bit period minus one, in clk_i cycles.
- `parity_en_i`  in  1  1 = append a parity bit.
- `parity_odd_i`  in  1  1 = odd parity, 0 = even parity. Ignored when parity is disabled.
- `stop2_i`  in  1  1 = two stop bits, 0 = one stop bit.
- `data_i`  in  DATA_W  word to transmit.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  FIFO can accept a word; equals !full.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `busy_o`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `tx_o`  out  1  serial output; idles high.

## Operation
- **Push:** a word is written on any edge where `valid_i && ready_o`.
- **Pop:** a word is read when the FSM leaves IDLE or STOP toward START.
  - Push and pop in the same cycle are both honoured; `level_o` is then unchanged.
- **Config latch:** `divider_i`, `parity_en_i`, `parity_odd_i` and `stop2_i` are latched on entry to START. Changes mid-frame do not affect the current frame.
- **Parity:** even = XOR of the data bits; odd = its inverse. It is computed on the popped word.
- **Bit counter:** loads the latched divider at each bit start and decrements to 0. Each bit is held divider+1 cycles; divider 0 gives one cycle per bit.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx_o` = 1. If the FIFO is non-empty, pop and go to START.
  - START: `tx_o` = 0 for one bit period, then go to DATA with bit index 0.
  - DATA: `tx_o` = shift[0] for one bit period; shift right, increment the index. After bit `DATA_W-1`, go to PARITY if parity is enabled, else STOP.
  - PARITY: `tx_o` = parity bit for one bit period, then go to STOP.
  - STOP: `tx_o` = 1 for one period, or two periods if `stop2_i` was latched. At the end, pop and go to START if the FIFO is non-empty (no idle gap), else go to IDLE.
- **Unreachable state encodings** recover to IDLE with `tx_o` = 1.
- **Frame length:** (1 + DATA_W + P + S) × (divider+1) cycles, where P ∈ {0,1} and S ∈ {1,2}.

## Timing
- **Reset values:**
  - `tx_o` = 1, `ready_o` = 1, `busy_o` = 0, `level_o` = 0.
  - FSM in IDLE, FIFO empty, counters 0.
- **Mid-operation reset:** asynchronous assertion aborts any frame and clears the FIFO. `tx_o` returns to 1 without waiting for a clock.
- **Start latency:** push at edge N into an empty FIFO with the FSM in IDLE means:
  - pop at edge N+1;
  - `tx_o` falls after edge N+1.
- **Registered outputs:** `ready_o` and `level_o` reflect the push/pop of edge N immediately after edge N. `tx_o` is a register output.
- **`busy_o`:** falls after the edge that ends the last stop bit with the FIFO empty.
- **Full FIFO:** `ready_o` = 0 and `valid_i` is ignored. There is no same-cycle "pop frees a slot" bypass.

## Test plan
- **8N1 single word:** `DATA_W`=8, divider=3, parity off, 1 stop, push 0x55.
  - `tx_o` = 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; 40 cycles total.
  - `busy_o` is high for exactly that window.
- **Parity:** push 0x07 with even parity → parity bit 1. Push 0x07 with odd parity → 0. Push 0x00 with even parity → 0. Two stop bits → `tx_o` high for 8 cycles at divider=3.
- **Back-pressure:** divider=9, `DEPTH`=4, `valid_i` held high with 6 words.
  - Exactly 5 words are accepted; `ready_o` is low after the 5th push with `level_o`=4.
  - All 5 frames are emitted back-to-back with no idle cycle between stop and start.
- **Config change mid-frame:** change divider 3→7 during DATA.
  - The current frame keeps 4-cycle bits.
  - The next frame uses 8-cycle bits.
- **Divider 0 and `DATA_W`=5:** push 0x1F (5 data bits), parity off, 1 stop → frame of 7 single-cycle bits: 0,1,1,1,1,1,1.
- **Reset mid-frame:** assert `rst_ni` during DATA with 2 words queued.
  - `tx_o`=1, `level_o`=0, `ready_o`=1 immediately.
  - No further frames are sent after release.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter with input FIFO and runtime frame format.
// Each word is sent as a start bit, DATA_W data bits (LSB first), an optional
// parity bit and one or two stop bits. Frame configuration is captured when a
// frame starts, so it can be changed while a frame is in flight.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   S_IDLE   | line high, waiting for a word in the FIFO
//   S_START  | driving the start bit (0)
//   S_DATA   | shifting out data bits, LSB first
//   S_PARITY | driving the parity bit
//   S_STOP   | driving one or two stop bits (1)
module uart_tx_frame #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 14,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DIV_W-1:0]         divider_i,
  input  logic                     parity_en_i,
  input  logic                     parity_odd_i,
  input  logic                     stop2_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o,
  output logic                     tx_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(DATA_W);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_q;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              stop2_q, stop2_d;
  logic              par_bit_q, par_bit_d;
  logic              second_q, second_d;
  logic              tx_q, tx_d;
  logic              load;

  assign ready_o = (level_q != FULL_LVL);
  assign push    = valid_i && ready_o;
  assign head    = mem[rd_ptr];
  assign level_o = level_q;
  assign busy_o  = (state_q != S_IDLE) || (level_q != '0);
  assign tx_o    = tx_q;

  // FIFO storage; no reset needed since reads are gated by the level
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave level unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Transmit state register; tx idles high and returns high on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      second_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      second_q  <= second_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic; tx_d is the line level for the bit that starts at the next edge
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    par_bit_d = par_bit_q;
    second_d  = second_q;
    tx_d      = tx_q;
    load      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (level_q != '0) load = 1'b1;
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          idx_d   = '0;
          cnt_d   = div_q;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q;
          if (idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d  = S_STOP;
              second_d = 1'b0;
              tx_d     = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IW'(1);
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d  = S_STOP;
          second_d = 1'b0;
          cnt_d    = div_q;
          tx_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == '0) begin
          if (stop2_q && !second_q) begin
            second_d = 1'b1;
            cnt_d    = div_q;
          end else if (level_q != '0) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Frame start: pop the head word and capture the frame format for this frame
    if (load) begin
      pop       = 1'b1;
      state_d   = S_START;
      cnt_d     = divider_i;
      div_d     = divider_i;
      par_en_d  = parity_en_i;
      stop2_d   = stop2_i;
      par_bit_d = (^head) ^ parity_odd_i;
      shift_d   = head;
      tx_d      = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a queue-based line model checked every cycle,
// directed frames with hand-derived waveforms, and a randomized phase.
module tb_uart_tx_frame;
  localparam int DW    = 8;
  localparam int DIVW  = 14;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [DIVW-1:0] divider    = '0;
  logic            parity_en  = 1'b0;
  logic            parity_odd = 1'b0;
  logic            stop2      = 1'b0;
  logic [DW-1:0]   data       = '0;
  logic            valid      = 1'b0;
  logic            ready;
  logic [LW-1:0]   level;
  logic            busy;
  logic            tx;

  uart_tx_frame #(.DATA_W(DW), .DIV_W(DIVW), .DEPTH(DEPTH)) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .divider_i   (divider),
    .parity_en_i (parity_en),
    .parity_odd_i(parity_odd),
    .stop2_i     (stop2),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .level_o     (level),
    .busy_o      (busy),
    .tx_o        (tx)
  );

  // Narrow instance: 5 data bits, 2-deep FIFO, fixed 5N1 format
  logic [3:0] divider5 = '0;
  logic [4:0] data5    = '0;
  logic       valid5   = 1'b0;
  logic       ready5;
  logic [1:0] level5;
  logic       busy5;
  logic       tx5;

  uart_tx_frame #(.DATA_W(5), .DIV_W(4), .DEPTH(2)) u_dut5 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .divider_i   (divider5),
    .parity_en_i (1'b0),
    .parity_odd_i(1'b0),
    .stop2_i     (1'b0),
    .data_i      (data5),
    .valid_i     (valid5),
    .ready_o     (ready5),
    .level_o     (level5),
    .busy_o      (busy5),
    .tx_o        (tx5)
  );

  int tests = 0;
  int fails = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_fifo holds accepted words; m_wave holds the per-cycle line levels of the
  // frame currently being sent. A new frame starts on the edge after the
  // previous frame's last cycle, if a word is waiting.
  logic [DW-1:0] m_fifo[$];
  logic          m_wave[$];
  logic          m_tx     = 1'b1;
  logic          m_active = 1'b0;
  logic          m_push;

  function automatic void m_build(input logic [DW-1:0] w);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (parity_en) bits.push_back((^w) ^ parity_odd);
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[b])
      for (int k = 0; k <= int'(divider); k++) m_wave.push_back(bits[b]);
  endfunction

  initial begin : model_and_compare
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        m_fifo.delete();
        m_wave.delete();
        m_tx     = 1'b1;
        m_active = 1'b0;
      end else begin
        m_push = valid && (m_fifo.size() < DEPTH);
        if (m_wave.size() == 0 && m_fifo.size() > 0) m_build(m_fifo.pop_front());
        if (m_wave.size() > 0) begin
          m_tx     = m_wave.pop_front();
          m_active = 1'b1;
        end else begin
          m_tx     = 1'b1;
          m_active = 1'b0;
        end
        if (m_push) m_fifo.push_back(data);
      end
      #1;
      check1("m_tx", tx, m_tx);
      checkn("m_level", int'(level), m_fifo.size());
      check1("m_ready", ready, m_fifo.size() < DEPTH);
      check1("m_busy", busy, m_active || (m_fifo.size() > 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic cap_tx[64];
  logic cap_busy[64];

  // Caller is at a negedge; word is pushed on the next posedge.
  task automatic push_one(input logic [DW-1:0] w);
    data  = w;
    valid = 1'b1;
    @(negedge clk_i);
    valid = 1'b0;
  endtask

  // Sample index 0 is the line right after the edge that follows the push.
  task automatic capture(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk_i);
      #1;
      cap_tx[j]   = tx;
      cap_busy[j] = busy;
    end
    @(negedge clk_i);
  endtask

  // Counts post-edge samples with busy high until busy drops.
  task automatic wait_idle(input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk_i);
      #1;
      if (!busy) break;
      n++;
    end
    check1("idle_timeout", busy, 1'b0);
    @(negedge clk_i);
  endtask

  task automatic set_cfg(input int div, input logic pe, input logic po, input logic s2);
    divider    = DIVW'(div);
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
  endtask

  logic exp55[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic exp1f[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int acc;
    int zeros;
    logic [DW-1:0] bp_words[6];

    repeat (2) @(negedge clk_i);
    check1("rst_tx", tx, 1'b1);
    check1("rst_ready", ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    checkn("rst_level", int'(level), 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // 8N1, divider 3, word 0x55: 10 bits of 4 cycles, busy drops at sample 40
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    push_one(8'h55);
    capture(44);
    for (int b = 0; b < 10; b++) begin
      check1("8n1_first", cap_tx[b*4], exp55[b]);
      check1("8n1_last", cap_tx[b*4+3], exp55[b]);
    end
    check1("8n1_idle_tx", cap_tx[40], 1'b1);
    check1("8n1_busy_end", cap_busy[39], 1'b1);
    check1("8n1_busy_low", cap_busy[40], 1'b0);

    // Parity bit is bit 9 of the frame, sample 36 at divider 3
    set_cfg(3, 1'b1, 1'b0, 1'b0);
    push_one(8'h07);
    capture(46);
    check1("par_even_07", cap_tx[36], 1'b1);
    check1("par_busy_low", cap_busy[44], 1'b0);
    set_cfg(3, 1'b1, 1'b1, 1'b0);
    push_one(8'h07);
    capture(46);
    check1("par_odd_07", cap_tx[36], 1'b0);
    set_cfg(3, 1'b1, 1'b0, 1'b0);
    push_one(8'h00);
    capture(46);
    check1("par_even_00", cap_tx[36], 1'b0);

    // Two stop bits: samples 36..43 high, busy low at 44
    set_cfg(3, 1'b0, 1'b0, 1'b1);
    push_one(8'h00);
    capture(46);
    check1("stop2_data7", cap_tx[35], 1'b0);
    check1("stop2_first", cap_tx[36], 1'b1);
    check1("stop2_last", cap_tx[43], 1'b1);
    check1("stop2_busy_hi", cap_busy[43], 1'b1);
    check1("stop2_busy_low", cap_busy[44], 1'b0);

    // Back-pressure: 6 words offered on consecutive edges, 5 fit
    set_cfg(9, 1'b0, 1'b0, 1'b0);
    bp_words = '{8'hA1, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'h77};
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      data  = bp_words[k];
      valid = 1'b1;
      if (ready) acc++;
      @(negedge clk_i);
      if (k == 4) begin
        checkn("bp_level_full", int'(level), 4);
        check1("bp_ready_low", ready, 1'b0);
      end
    end
    valid = 1'b0;
    checkn("bp_accepted", acc, 5);
    // 5 back-to-back 100-cycle frames start after edge N+1 and end at N+501;
    // samples from edge N+6 to N+500 are busy
    wait_idle(2000, n);
    checkn("bp_busy_cycles", n, 495);

    // Divider changed 3 -> 7 while the first of two frames is in DATA:
    // frame 1 is 40 cycles, frame 2 is 80, idle at edge N+121
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    push_one(8'hC3);
    push_one(8'h96);
    repeat (10) @(negedge clk_i);
    divider = DIVW'(7);
    wait_idle(2000, n);
    checkn("cfg_busy_cycles", n, 109);

    // 5-bit instance, divider 0, word 0x1F
    divider5 = 4'd0;
    data5    = 5'h1F;
    valid5   = 1'b1;
    @(negedge clk_i);
    valid5 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk_i);
      #1;
      check1("w5_tx", tx5, exp1f[j]);
      check1("w5_busy", busy5, j < 7);
    end
    @(negedge clk_i);

    // Reset while sending with 2 words still queued
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    push_one(8'h00);
    push_one(8'h00);
    push_one(8'h00);
    repeat (8) @(negedge clk_i);
    check1("mid_tx_before", tx, 1'b0);
    checkn("mid_level_before", int'(level), 2);
    #2;
    rst_ni = 1'b0;
    #1;
    check1("mid_rst_tx", tx, 1'b1);
    checkn("mid_rst_level", int'(level), 0);
    check1("mid_rst_ready", ready, 1'b1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    zeros = 0;
    for (int j = 0; j < 100; j++) begin
      @(posedge clk_i);
      #1;
      if (tx !== 1'b1) zeros++;
    end
    @(negedge clk_i);
    checkn("mid_no_frames", zeros, 0);

    // Randomized traffic and format changes, checked by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      valid = ($urandom_range(0, 3) == 0);
      data  = DW'($urandom);
      if ($urandom_range(0, 39) == 0)
        set_cfg($urandom_range(0, 4), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk_i);
    valid = 1'b0;
    wait_idle(2000, n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
